// File: rtl/adam_mem_prof_if.sv
`default_nettype none
// ============================================================================
//  Module   : adam_mem_prof_if
//  Purpose  : Bundles the tapped memory port (req/we/be) and the snapshot
//             valid/ready stream of the memory-traffic profiler.
//  Ports    : master - drives the tap and snap_ready, observes snapshots
//             slave  - the profiler: observes the tap, produces snapshots
//  Revision : 1.0 - initial release
// ============================================================================
interface adam_mem_prof_if #(
   parameter int unsigned STRB_WIDTH = 4,
   parameter int unsigned CNT_WIDTH  = 32
) ();

   // tapped memory port
   logic                  mon_req;
   logic                  mon_we;
   logic [STRB_WIDTH-1:0] mon_be;

   // snapshot stream
   logic                  snap_valid;
   logic                  snap_ready;
   logic [CNT_WIDTH-1:0]  snap_rd_ops;
   logic [CNT_WIDTH-1:0]  snap_wr_ops;
   logic [CNT_WIDTH-1:0]  snap_rd_bytes;
   logic [CNT_WIDTH-1:0]  snap_wr_bytes;
   logic                  snap_sat;
   logic [CNT_WIDTH-1:0]  snap_dropped;

   modport master (
      output mon_req, mon_we, mon_be, snap_ready,
      input  snap_valid, snap_rd_ops, snap_wr_ops, snap_rd_bytes,
             snap_wr_bytes, snap_sat, snap_dropped
   );

   modport slave (
      input  mon_req, mon_we, mon_be, snap_ready,
      output snap_valid, snap_rd_ops, snap_wr_ops, snap_rd_bytes,
             snap_wr_bytes, snap_sat, snap_dropped
   );

endinterface
`default_nettype wire

// File: rtl/adam_mem_prof.sv
`default_nettype none
// ============================================================================
//  Module   : adam_mem_prof
//  Purpose  : Passive memory-traffic profiler. After a start delay it counts
//             read/write operations and bytes over fixed cycle windows and
//             publishes one snapshot per window on a valid/ready stream.
//  Ports    : clk_i   - clock
//             rst_i   - synchronous active-high reset
//             en_i    - profiler enable
//             clear_i - one-cycle pulse, restarts the current window
//             busy_o  - high while in DELAY or RUN
//             mon     - tap inputs and snapshot stream (slave modport)
//  Revision : 1.0 - initial release
// ============================================================================
module adam_mem_prof #(
   parameter int unsigned STRB_WIDTH  = 4,
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned START_DELAY = 100000,
   parameter int unsigned WINDOW      = 1024
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           en_i,
   input  logic           clear_i,
   output logic           busy_o,
   adam_mem_prof_if.slave mon
);

   localparam int unsigned c_DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [c_DLY_W-1:0] c_DLY_LAST =
      (START_DELAY > 0) ? c_DLY_W'(START_DELAY - 1) : '0;
   localparam int unsigned c_WIN_W = $clog2(WINDOW);
   localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);
   localparam int unsigned c_PC_W = $clog2(STRB_WIDTH + 1);
   localparam logic [CNT_WIDTH:0] c_ONE      = (CNT_WIDTH+1)'(1);
   localparam logic [CNT_WIDTH:0] c_RD_BYTES = (CNT_WIDTH+1)'(STRB_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // Saturating add; MSB of the result flags that clamping occurred.
   function automatic logic [CNT_WIDTH:0] f_sat_add(
      input logic [CNT_WIDTH-1:0] a,
      input logic [CNT_WIDTH:0]   b
   );
      logic [CNT_WIDTH+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      if (s > {2'b00, {CNT_WIDTH{1'b1}}})
         return {1'b1, {CNT_WIDTH{1'b1}}};
      return {1'b0, s[CNT_WIDTH-1:0]};
   endfunction

   function automatic logic [c_PC_W-1:0] f_popcount(input logic [STRB_WIDTH-1:0] v);
      logic [c_PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < STRB_WIDTH; i++)
         n = n + c_PC_W'(v[i]);
      return n;
   endfunction

   state_t               state_q, state_d;
   logic [c_DLY_W-1:0]   dly_q, dly_d;
   logic [c_WIN_W-1:0]   win_q, win_d;
   logic [CNT_WIDTH-1:0] rd_ops_q, rd_ops_d;
   logic [CNT_WIDTH-1:0] wr_ops_q, wr_ops_d;
   logic [CNT_WIDTH-1:0] rd_bytes_q, rd_bytes_d;
   logic [CNT_WIDTH-1:0] wr_bytes_q, wr_bytes_d;
   logic                 sat_q, sat_d;
   logic [CNT_WIDTH-1:0] drop_q, drop_d;
   logic                 busy_q;

   logic                 snap_valid_q, snap_valid_d;
   logic [CNT_WIDTH-1:0] snap_rd_ops_q, snap_rd_ops_d;
   logic [CNT_WIDTH-1:0] snap_wr_ops_q, snap_wr_ops_d;
   logic [CNT_WIDTH-1:0] snap_rd_bytes_q, snap_rd_bytes_d;
   logic [CNT_WIDTH-1:0] snap_wr_bytes_q, snap_wr_bytes_d;
   logic                 snap_sat_q, snap_sat_d;
   logic [CNT_WIDTH-1:0] snap_dropped_q, snap_dropped_d;

   logic                 w_rd_hit, w_wr_hit, w_accept, w_sat_new;
   logic [CNT_WIDTH:0]   w_rd_ops_s, w_wr_ops_s, w_rd_bytes_s, w_wr_bytes_s;

   assign w_rd_hit = mon.mon_req & ~mon.mon_we;
   assign w_wr_hit = mon.mon_req &  mon.mon_we;
   assign w_accept = snap_valid_q & mon.snap_ready;

   // Candidate counter values including this cycle's access.
   assign w_rd_ops_s   = f_sat_add(rd_ops_q,   w_rd_hit ? c_ONE : '0);
   assign w_rd_bytes_s = f_sat_add(rd_bytes_q, w_rd_hit ? c_RD_BYTES : '0);
   assign w_wr_ops_s   = f_sat_add(wr_ops_q,   w_wr_hit ? c_ONE : '0);
   assign w_wr_bytes_s = f_sat_add(wr_bytes_q,
                            w_wr_hit ? (CNT_WIDTH+1)'(f_popcount(mon.mon_be)) : '0);
   assign w_sat_new    = sat_q | w_rd_ops_s[CNT_WIDTH] | w_rd_bytes_s[CNT_WIDTH]
                       | w_wr_ops_s[CNT_WIDTH] | w_wr_bytes_s[CNT_WIDTH];

   always_comb begin
      state_d         = state_q;
      dly_d           = dly_q;
      win_d           = win_q;
      rd_ops_d        = rd_ops_q;
      wr_ops_d        = wr_ops_q;
      rd_bytes_d      = rd_bytes_q;
      wr_bytes_d      = wr_bytes_q;
      sat_d           = sat_q;
      drop_d          = drop_q;
      snap_valid_d    = snap_valid_q;
      snap_rd_ops_d   = snap_rd_ops_q;
      snap_wr_ops_d   = snap_wr_ops_q;
      snap_rd_bytes_d = snap_rd_bytes_q;
      snap_wr_bytes_d = snap_wr_bytes_q;
      snap_sat_d      = snap_sat_q;
      snap_dropped_d  = snap_dropped_q;

      if (w_accept)
         snap_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            dly_d      = '0;
            win_d      = '0;
            rd_ops_d   = '0;
            wr_ops_d   = '0;
            rd_bytes_d = '0;
            wr_bytes_d = '0;
            sat_d      = 1'b0;
            if (en_i)
               state_d = (START_DELAY == 0) ? ST_RUN : ST_DELAY;
         end

         ST_DELAY: begin
            if (!en_i)
               state_d = ST_IDLE;
            else if (clear_i)
               dly_d = '0;
            else if (dly_q == c_DLY_LAST)
               state_d = ST_RUN;
            else
               dly_d = dly_q + c_DLY_W'(1);
         end

         ST_RUN: begin
            if (!en_i) begin
               // partial window is discarded; IDLE zeroes the live counters
               state_d = ST_IDLE;
            end else if (clear_i) begin
               // The clear cycle itself is slot 0 of the restarted window,
               // with its access dropped, so the next slot is 1.
               rd_ops_d   = '0;
               wr_ops_d   = '0;
               rd_bytes_d = '0;
               wr_bytes_d = '0;
               sat_d      = 1'b0;
               win_d      = c_WIN_W'(1);
            end else if (win_q == c_WIN_LAST) begin
               rd_ops_d   = '0;
               wr_ops_d   = '0;
               rd_bytes_d = '0;
               wr_bytes_d = '0;
               sat_d      = 1'b0;
               win_d      = '0;
               if (!snap_valid_q || w_accept) begin
                  snap_valid_d    = 1'b1;
                  snap_rd_ops_d   = w_rd_ops_s[CNT_WIDTH-1:0];
                  snap_wr_ops_d   = w_wr_ops_s[CNT_WIDTH-1:0];
                  snap_rd_bytes_d = w_rd_bytes_s[CNT_WIDTH-1:0];
                  snap_wr_bytes_d = w_wr_bytes_s[CNT_WIDTH-1:0];
                  snap_sat_d      = w_sat_new;
                  snap_dropped_d  = drop_q;
                  drop_d          = '0;
               end else begin
                  drop_d = (&drop_q) ? drop_q : drop_q + CNT_WIDTH'(1);
               end
            end else begin
               rd_ops_d   = w_rd_ops_s[CNT_WIDTH-1:0];
               wr_ops_d   = w_wr_ops_s[CNT_WIDTH-1:0];
               rd_bytes_d = w_rd_bytes_s[CNT_WIDTH-1:0];
               wr_bytes_d = w_wr_bytes_s[CNT_WIDTH-1:0];
               sat_d      = w_sat_new;
               win_d      = win_q + c_WIN_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         dly_q           <= '0;
         win_q           <= '0;
         rd_ops_q        <= '0;
         wr_ops_q        <= '0;
         rd_bytes_q      <= '0;
         wr_bytes_q      <= '0;
         sat_q           <= 1'b0;
         drop_q          <= '0;
         busy_q          <= 1'b0;
         snap_valid_q    <= 1'b0;
         snap_rd_ops_q   <= '0;
         snap_wr_ops_q   <= '0;
         snap_rd_bytes_q <= '0;
         snap_wr_bytes_q <= '0;
         snap_sat_q      <= 1'b0;
         snap_dropped_q  <= '0;
      end else begin
         state_q         <= state_d;
         dly_q           <= dly_d;
         win_q           <= win_d;
         rd_ops_q        <= rd_ops_d;
         wr_ops_q        <= wr_ops_d;
         rd_bytes_q      <= rd_bytes_d;
         wr_bytes_q      <= wr_bytes_d;
         sat_q           <= sat_d;
         drop_q          <= drop_d;
         busy_q          <= (state_d == ST_DELAY) || (state_d == ST_RUN);
         snap_valid_q    <= snap_valid_d;
         snap_rd_ops_q   <= snap_rd_ops_d;
         snap_wr_ops_q   <= snap_wr_ops_d;
         snap_rd_bytes_q <= snap_rd_bytes_d;
         snap_wr_bytes_q <= snap_wr_bytes_d;
         snap_sat_q      <= snap_sat_d;
         snap_dropped_q  <= snap_dropped_d;
      end
   end

   assign busy_o            = busy_q;
   assign mon.snap_valid    = snap_valid_q;
   assign mon.snap_rd_ops   = snap_rd_ops_q;
   assign mon.snap_wr_ops   = snap_wr_ops_q;
   assign mon.snap_rd_bytes = snap_rd_bytes_q;
   assign mon.snap_wr_bytes = snap_wr_bytes_q;
   assign mon.snap_sat      = snap_sat_q;
   assign mon.snap_dropped  = snap_dropped_q;

endmodule
`default_nettype wire
